uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that succeeds the single-word UART_TX. It adds configurable data width, parity mode and stop-bit count, plus an input FIFO so that frames go out back-to-back with no idle gap. Bit timing comes from the external baud-enable pulse UART_CLK_EN, produced by the shared baud generator. It sits between the speech-result formatter and the board TXD pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bit periods; 1 or 2.
FIFO_DEPTH, 4, number of FIFO words; power of two, 2..16.
CW, $clog2(FIFO_DEPTH)+1, width of FIFO_COUNT; derived, do not override.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-low reset.
UART_CLK_EN  in  1  one-CLK-wide pulse; one pulse = one bit period.
DATA_IN  in  DATA_WIDTH  payload word to push.
DATA_SEND  in  1  push strobe; DATA_IN is sampled on this edge.
DATA_READY  out  1  FIFO not full; a push is accepted only while this is 1.
OVERFLOW  out  1  one-cycle pulse when DATA_SEND=1 and DATA_READY=0.
UART_TXD  out  1  registered serial output; idles high.
BUSY  out  1  1 when the FSM is not in IDLE or the FIFO is non-empty.
FIFO_COUNT  out  CW  number of words held, 0..FIFO_DEPTH.
STATE  out  3  FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Behaviour:
- Reset (RST=0, asynchronous). Forces: UART_TXD=1, STATE=IDLE, FIFO empty (FIFO_COUNT=0), DATA_READY=1, BUSY=0, OVERFLOW=0. Bit and stop counters clear. A frame in flight is aborted with no completion, and the line returns high at once.
- FIFO push. DATA_SEND=1 with DATA_READY=1 writes DATA_IN; FIFO_COUNT increments next cycle. DATA_READY is 1 when FIFO_COUNT<FIFO_DEPTH, taken from the registered count.
- Full FIFO. DATA_SEND=1 while full drops the word and pulses OVERFLOW. This holds even when a pop happens in the same cycle.
- Simultaneous push and pop (not full). FIFO_COUNT stays unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM transitions. All transitions and UART_TXD updates happen only on cycles where UART_CLK_EN=1. UART_CLK_EN=0 holds all state.
  - IDLE: UART_TXD=1. On EN with FIFO non-empty: pop into the shift register, UART_TXD<=0, go to START.
  - START: on EN, UART_TXD<=bit0 (LSB first), bit counter<=1, go to DATA.
  - DATA: on EN, if counter<DATA_WIDTH, drive the next bit and increment the counter. Otherwise go to PARITY with UART_TXD<=parity, or, if PARITY_MODE=0, go to STOP with UART_TXD<=1.
  - Parity value: even mode drives the XOR of the payload bits; odd mode drives its inverse.
  - PARITY: on EN, UART_TXD<=1 and go to STOP.
  - STOP: the line stays high for STOP_BITS EN periods. At the EN that ends the last stop period: if the FIFO is non-empty, pop, UART_TXD<=0, go to START (back-to-back); else go to IDLE.
- Frame length. Exactly 1+DATA_WIDTH+(PARITY_MODE!=0)+STOP_BITS EN periods.
- Payload latching. The word is latched at pop, so FIFO activity during a frame never corrupts it.
- FIFO_COUNT decrements on the pop cycle.
- UART_TXD is glitch-free because it comes straight from a register.

Test Plan:
1. Basic frame (DATA_WIDTH=8, PARITY_MODE=0, STOP_BITS=1). Push 0x5A while idle. -> UART_TXD over EN periods: 0, then 0,1,0,1,1,0,1,0, then 1. BUSY falls after 10 periods. STATE passes 0→1→2→4→0.
2. Parity modes. Push 0x5A with PARITY_MODE=1 -> parity bit 0. Push 0x5B with PARITY_MODE=1 -> parity bit 1. PARITY_MODE=2 inverts both results. Frames are 11 periods long.
3. Back-to-back frames (FIFO_DEPTH=4). Push 0x11, 0x22, 0x33 on consecutive CLK cycles. -> FIFO_COUNT goes 1,2,3, then falls as words pop. Start bits follow the stop bits with zero idle periods; 30 periods in total.
4. Overflow. With TX stalled (UART_CLK_EN=0), push 5 words. -> DATA_READY=0 after the 4th word; OVERFLOW pulses on the 5th; FIFO_COUNT=4. Resuming EN transmits the first 4 words only.
5. Two stop bits and DATA_WIDTH=7. Push 7'h41. -> frame is 0,1,0,0,0,0,0,1,1,1 (10 periods).
6. Reset mid-frame. Assert RST low during DATA of the 2nd queued word. -> UART_TXD=1, FIFO_COUNT=0, STATE=0 immediately, without waiting for a CLK edge. No further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Bits advance only on UART_CLK_EN. Queued frames go out back-to-back.
// A push is accepted while DATA_READY=1. A push into a full FIFO is dropped, and OVERFLOW pulses on the next cycle.
module uart_tx_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  UART_CLK_EN,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  DATA_SEND,
   output logic                  DATA_READY,
   output logic                  OVERFLOW,
   output logic                  UART_TXD,
   output logic                  BUSY,
   output logic [CW-1:0]         FIFO_COUNT,
   output logic [2:0]            STATE
);
   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [3:0]    DW_C    = 4'(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wptr, r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [3:0]            r_bitcnt, w_bitcnt_nxt;
   logic                  r_stopcnt, w_stopcnt_nxt;
   logic                  r_parity, w_parity_nxt;
   logic                  r_txd, w_txd_nxt;
   logic                  w_full, w_empty, w_push, w_pop;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);
   assign w_push  = DATA_SEND && !w_full;
   assign w_head  = r_mem[r_rptr];

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wptr] <= DATA_IN;
   end

   // Full is judged on the registered count, so a same-cycle pop never rescues a push.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= DATA_SEND && w_full;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_parity  <= 1'b0;
         r_txd     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_stopcnt <= w_stopcnt_nxt;
         r_parity  <= w_parity_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bitcnt_nxt  = r_bitcnt;
      w_stopcnt_nxt = r_stopcnt;
      w_parity_nxt  = r_parity;
      w_txd_nxt     = r_txd;
      w_pop         = 1'b0;
      if (UART_CLK_EN) begin
         case (r_state)
            S_IDLE: begin
               w_txd_nxt = 1'b1;
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_shift_nxt  = w_head;
                  w_parity_nxt = (PARITY_MODE == 2) ? ~^w_head : ^w_head;
                  w_txd_nxt    = 1'b0;
                  w_state_nxt  = S_START;
               end
            end
            S_START: begin
               w_txd_nxt    = r_shift[0];
               w_shift_nxt  = r_shift >> 1;
               w_bitcnt_nxt = 4'd1;
               w_state_nxt  = S_DATA;
            end
            S_DATA: begin
               if (r_bitcnt < DW_C) begin
                  w_txd_nxt    = r_shift[0];
                  w_shift_nxt  = r_shift >> 1;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (PARITY_MODE != 0) begin
                  w_txd_nxt   = r_parity;
                  w_state_nxt = S_PARITY;
               end else begin
                  w_txd_nxt   = 1'b1;
                  w_state_nxt = S_STOP;
               end
            end
            S_PARITY: begin
               w_txd_nxt   = 1'b1;
               w_state_nxt = S_STOP;
            end
            S_STOP: begin
               if (STOP_BITS == 2 && !r_stopcnt) begin
                  w_stopcnt_nxt = 1'b1;
               end else begin
                  w_stopcnt_nxt = 1'b0;
                  if (!w_empty) begin
                     w_pop        = 1'b1;
                     w_shift_nxt  = w_head;
                     w_parity_nxt = (PARITY_MODE == 2) ? ~^w_head : ^w_head;
                     w_txd_nxt    = 1'b0;
                     w_state_nxt  = S_START;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: begin
               w_txd_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign DATA_READY = !w_full;
   assign OVERFLOW   = r_overflow;
   assign UART_TXD   = r_txd;
   assign BUSY       = (r_state != S_IDLE) || !w_empty;
   assign FIFO_COUNT = r_count;
   assign STATE      = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover the parity modes, 7-bit data and two stop bits.
module tb_uart_tx_fifo;
   logic       CLK;
   logic       RST;
   logic       en;
   logic       send [4];
   logic [7:0] din  [3];
   logic [6:0] din3;
   logic       ready[4];
   logic       ovf  [4];
   logic       txd  [4];
   logic       busy [4];
   logic [2:0] cnt  [4];
   logic [2:0] st   [4];

   int total = 0;
   int bad   = 0;

   uart_tx_fifo #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
      .CLK(CLK), .RST(RST), .UART_CLK_EN(en), .DATA_IN(din[0]), .DATA_SEND(send[0]),
      .DATA_READY(ready[0]), .OVERFLOW(ovf[0]), .UART_TXD(txd[0]), .BUSY(busy[0]),
      .FIFO_COUNT(cnt[0]), .STATE(st[0]));
   uart_tx_fifo #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
      .CLK(CLK), .RST(RST), .UART_CLK_EN(en), .DATA_IN(din[1]), .DATA_SEND(send[1]),
      .DATA_READY(ready[1]), .OVERFLOW(ovf[1]), .UART_TXD(txd[1]), .BUSY(busy[1]),
      .FIFO_COUNT(cnt[1]), .STATE(st[1]));
   uart_tx_fifo #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
      .CLK(CLK), .RST(RST), .UART_CLK_EN(en), .DATA_IN(din[2]), .DATA_SEND(send[2]),
      .DATA_READY(ready[2]), .OVERFLOW(ovf[2]), .UART_TXD(txd[2]), .BUSY(busy[2]),
      .FIFO_COUNT(cnt[2]), .STATE(st[2]));
   uart_tx_fifo #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
      .CLK(CLK), .RST(RST), .UART_CLK_EN(en), .DATA_IN(din3), .DATA_SEND(send[3]),
      .DATA_READY(ready[3]), .OVERFLOW(ovf[3]), .UART_TXD(txd[3]), .BUSY(busy[3]),
      .FIFO_COUNT(cnt[3]), .STATE(st[3]));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One baud period: a single EN pulse with idle clocks around it; returns #1 after the EN edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      en = 1'b1;
      @(posedge CLK);
      #1;
      en = 1'b0;
   endtask

   task automatic push(input int k, input logic [7:0] d);
      @(negedge CLK);
      if (k == 3) din3 = d[6:0];
      else        din[k] = d;
      send[k] = 1'b1;
      @(posedge CLK);
      #1;
      send[k] = 1'b0;
   endtask

   task automatic check_frame(input int k, input logic [63:0] exp, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk($sformatf("%s bit%0d", tag, i), 64'(txd[k]), 64'(exp[i]));
      end
   endtask

   logic [2:0] st1   [10] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4};
   logic [7:0] f1          = 8'h5A;
   logic [2:0] cnt4  [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
   logic       rdy4  [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic       ovf4  [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [63:0] exp_w;

   initial begin
      RST = 1'b0;
      en  = 1'b0;
      for (int k = 0; k < 4; k++) send[k] = 1'b0;
      for (int k = 0; k < 3; k++) din[k] = '0;
      din3 = '0;

      #12;
      chk("rst txd", 64'(txd[0]), 64'd1);
      chk("rst cnt", 64'(cnt[0]), 64'd0);
      chk("rst ready", 64'(ready[0]), 64'd1);
      chk("rst busy", 64'(busy[0]), 64'd0);
      chk("rst ovf", 64'(ovf[0]), 64'd0);
      chk("rst state", 64'(st[0]), 64'd0);
      chk("rst txd d3", 64'(txd[3]), 64'd1);
      @(negedge CLK);
      RST = 1'b1;

      // Basic 8N1 frame of 0x5A, with the state walk checked each period.
      push(0, 8'h5A);
      chk("t1 cnt after push", 64'(cnt[0]), 64'd1);
      chk("t1 busy after push", 64'(busy[0]), 64'd1);
      exp_w = 64'({1'b1, f1, 1'b0});
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("t1 txd%0d", i), 64'(txd[0]), 64'(exp_w[i]));
         chk($sformatf("t1 st%0d", i), 64'(st[0]), 64'(st1[i]));
      end
      chk("t1 busy in stop", 64'(busy[0]), 64'd1);
      tick();
      chk("t1 busy end", 64'(busy[0]), 64'd0);
      chk("t1 st end", 64'(st[0]), 64'd0);

      // Parity: 0x5A has four ones, 0x5B has five.
      push(1, 8'h5A);
      check_frame(1, 64'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, "t2 even5A");
      tick();
      chk("t2 even5A idle", 64'(st[1]), 64'd0);
      push(1, 8'h5B);
      check_frame(1, 64'({1'b1, 1'b1, 8'h5B, 1'b0}), 11, "t2 even5B");
      tick();
      chk("t2 even5B idle", 64'(st[1]), 64'd0);
      push(2, 8'h5A);
      check_frame(2, 64'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, "t2 odd5A");
      tick();
      chk("t2 odd5A idle", 64'(st[2]), 64'd0);
      push(2, 8'h5B);
      check_frame(2, 64'({1'b1, 1'b0, 8'h5B, 1'b0}), 11, "t2 odd5B");
      tick();
      chk("t2 odd5B idle", 64'(st[2]), 64'd0);

      // Three consecutive pushes, then 30 periods with no idle gap.
      @(negedge CLK);
      send[0] = 1'b1;
      din[0]  = 8'h11;
      @(posedge CLK); #1;
      chk("t3 cnt1", 64'(cnt[0]), 64'd1);
      @(negedge CLK);
      din[0] = 8'h22;
      @(posedge CLK); #1;
      chk("t3 cnt2", 64'(cnt[0]), 64'd2);
      @(negedge CLK);
      din[0] = 8'h33;
      @(posedge CLK); #1;
      chk("t3 cnt3", 64'(cnt[0]), 64'd3);
      send[0] = 1'b0;
      exp_w = 64'({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
      check_frame(0, exp_w, 1, "t3 first");
      chk("t3 cnt after pop", 64'(cnt[0]), 64'd2);
      check_frame(0, exp_w >> 1, 29, "t3 rest");
      tick();
      chk("t3 st end", 64'(st[0]), 64'd0);
      chk("t3 busy end", 64'(busy[0]), 64'd0);
      chk("t3 cnt end", 64'(cnt[0]), 64'd0);

      // Overflow with EN stalled: the fifth word must be dropped.
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         send[0] = 1'b1;
         din[0]  = 8'hA1 + 8'(j);
         @(posedge CLK); #1;
         chk($sformatf("t4 cnt%0d", j), 64'(cnt[0]), 64'(cnt4[j]));
         chk($sformatf("t4 ready%0d", j), 64'(ready[0]), 64'(rdy4[j]));
         chk($sformatf("t4 ovf%0d", j), 64'(ovf[0]), 64'(ovf4[j]));
      end
      send[0] = 1'b0;
      @(posedge CLK); #1;
      chk("t4 ovf clears", 64'(ovf[0]), 64'd0);
      chk("t4 cnt held", 64'(cnt[0]), 64'd4);
      exp_w = {24'd0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0};
      check_frame(0, exp_w, 40, "t4 tx");
      tick();
      chk("t4 no fifth frame", 64'(st[0]), 64'd0);
      chk("t4 busy end", 64'(busy[0]), 64'd0);

      // 7 data bits, two stop bits.
      push(3, 8'h41);
      check_frame(3, 64'({1'b1, 1'b1, 7'h41, 1'b0}), 10, "t5 7n2");
      tick();
      chk("t5 st end", 64'(st[3]), 64'd0);
      chk("t5 busy end", 64'(busy[3]), 64'd0);

      // Reset in the middle of the second queued frame.
      push(0, 8'hC3);
      push(0, 8'h3C);
      check_frame(0, 64'({1'b1, 8'hC3, 1'b0}), 10, "t6 first");
      tick();
      tick();
      chk("t6 st data", 64'(st[0]), 64'd2);
      chk("t6 txd bit0", 64'(txd[0]), 64'd0);
      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      chk("t6 async txd", 64'(txd[0]), 64'd1);
      chk("t6 async cnt", 64'(cnt[0]), 64'd0);
      chk("t6 async st", 64'(st[0]), 64'd0);
      chk("t6 async busy", 64'(busy[0]), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("t6 quiet txd%0d", i), 64'(txd[0]), 64'd1);
      end
      chk("t6 quiet st", 64'(st[0]), 64'd0);
      chk("t6 quiet busy", 64'(busy[0]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
